// File: rtl/reg_dbg_port.sv
// Debug access port: halts the CPU, then reads or writes one register-file entry and returns a response.
// Define REG_DBG_DUMP_EN to add the DUMP state, which streams registers 0..31 as 32 responses.
module reg_dbg_port #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_dump,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        halt_req,
    input  logic        halt_ack,
    output logic [4:0]  rf_sel,
    input  logic [31:0] rf_val,
    output logic        rf_we,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wval
);

`ifdef REG_DBG_DUMP_EN
    typedef enum logic [2:0] {IDLE, HALT_WAIT, EXEC, RESP, DUMP, RELEASE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HALT_WAIT, EXEC, RESP, RELEASE} state_t;
`endif

    localparam logic [15:0] TIMEOUT_C = 16'(HALT_TIMEOUT);

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [4:0]  rsp_addr_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        halt_req_q;
    logic [4:0]  rf_sel_q;
    logic        rf_we_q;
    logic [4:0]  rf_wsel_q;
    logic [31:0] rf_wval_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

`ifdef REG_DBG_DUMP_EN
    logic        dump_q;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    assign idx_d = idx_q + 5'd1;
`else
    logic        dump_unused;
    assign dump_unused = cmd_dump;
`endif

    assign cnt_d = cnt_q + 16'd1;

    // Ready is masked by reset so it reads low while reset is held and high right after.
    assign cmd_ready = cmd_ready_q & ~reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign halt_req  = halt_req_q;
    assign rf_sel    = rf_sel_q;
    assign rf_we     = rf_we_q;
    assign rf_wsel   = rf_wsel_q;
    assign rf_wval   = rf_wval_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            halt_req_q  <= 1'b0;
            rf_sel_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wsel_q   <= '0;
            rf_wval_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
`ifdef REG_DBG_DUMP_EN
            dump_q      <= 1'b0;
            idx_q       <= '0;
`endif
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        write_q     <= cmd_write;
`ifdef REG_DBG_DUMP_EN
                        dump_q      <= cmd_dump;
`endif
                        halt_req_q  <= 1'b1;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    if (halt_ack) begin
                        state_q <= EXEC;
                        // The write strobe is registered here so it is high for the EXEC cycle only.
                        if (write_q) begin
                            rf_we_q   <= (addr_q != 5'd0);
                            rf_wsel_q <= addr_q;
                            rf_wval_q <= wdata_q;
                        end else begin
                            rf_sel_q  <= addr_q;
                        end
`ifdef REG_DBG_DUMP_EN
                        if (dump_q) begin
                            rf_we_q  <= 1'b0;
                            rf_sel_q <= '0;
                            idx_q    <= '0;
                            state_q  <= DUMP;
                        end
`endif
                    end else if (cnt_d == TIMEOUT_C) begin
                        cnt_q       <= cnt_d;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_addr_q  <= addr_q;
`ifdef REG_DBG_DUMP_EN
                        dump_q      <= 1'b0;
`endif
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= addr_q;
                    rf_sel_q    <= '0;
                    if (write_q) begin
                        rsp_err_q  <= (addr_q == 5'd0);
                        rsp_data_q <= (addr_q == 5'd0) ? 32'd0 : wdata_q;
                    end else begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= rf_val;
                    end
                    state_q <= RESP;
                end
`ifdef REG_DBG_DUMP_EN
                DUMP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= idx_q;
                    rsp_data_q  <= rf_val;
                    rsp_err_q   <= 1'b0;
                    rf_sel_q    <= '0;
                    state_q     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= RELEASE;
`ifdef REG_DBG_DUMP_EN
                        // Index 31 is the last entry; the index never wraps.
                        if (dump_q && (idx_q != 5'd31)) begin
                            idx_q    <= idx_d;
                            rf_sel_q <= idx_d;
                            state_q  <= DUMP;
                        end
`endif
                    end
                end
                RELEASE: begin
                    halt_req_q <= 1'b0;
                    if (!halt_ack) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    halt_req_q  <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dbg_port.sv
// Scoreboard bench for reg_dbg_port: directed commands push expected responses, a monitor pops and compares.
module tb_reg_dbg_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_dump = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        halt_req;
    logic        halt_ack = 1'b0;
    logic [4:0]  rf_sel;
    logic [31:0] rf_val;
    logic        rf_we;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wval;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          we_cnt = 0;
    logic [4:0]  last_wsel = '0;
    logic [31:0] last_wval = '0;
    logic        sb_en = 1'b1;
    logic        bp_en = 1'b0;
    logic        hold_low = 1'b0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    reg_dbg_port #(.HALT_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_dump(cmd_dump), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_sel(rf_sel), .rf_val(rf_val),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wval(rf_wval)
    );

    function automatic logic [31:0] pre(input int i);
        return (i == 29) ? 32'h0000FFFF : (32'hA5000000 | 32'(i));
    endfunction

    // Register file and CPU halt model
    assign rf_val = rf[rf_sel];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= pre(i);
        end else if (rf_we) begin
            rf[rf_wsel] <= rf_wval;
        end
        halt_ack <= hold_low ? 1'b0 : halt_req;
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = bp_en ? ~rsp_ready : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: payload stability while stalled, scoreboard on acceptance, write-strobe tracking
    initial begin
        logic stall_seen;
        rsp_t stall_p;
        rsp_t e;
        stall_seen = 1'b0;
        stall_p = '0;
        forever begin
            @(negedge clk);
            if (!reset && rf_we === 1'b1) begin
                we_cnt++;
                last_wsel = rf_wsel;
                last_wval = rf_wval;
            end
            if (sb_en && !reset) begin
                if (rsp_valid === 1'b1 && stall_seen) begin
                    chk("rsp_stable_addr", 32'(rsp_addr), 32'(stall_p.a));
                    chk("rsp_stable_data", rsp_data, stall_p.d);
                end
                if (rsp_valid === 1'b1 && rsp_ready) begin
                    stall_seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_addr), 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_addr", 32'(rsp_addr), 32'(e.a));
                        chk("rsp_data", rsp_data, e.d);
                        chk("rsp_err", 32'(rsp_err), 32'(e.e));
                    end
                end else if (rsp_valid === 1'b1) begin
                    stall_seen = 1'b1;
                    stall_p = '{a: rsp_addr, d: rsp_data, e: rsp_err};
                end else begin
                    stall_seen = 1'b0;
                end
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic send(input logic w, input logic d, input logic [4:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(n < 300), 32'd1);
        cmd_write = w;
        cmd_dump = d;
        cmd_addr = a;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_dump = 1'b0;
    endtask

    task automatic latency(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cmd_ready === 1'b1 && exp_q.size() == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 400), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int we0;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_halt_req", 32'(halt_req), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_sel", 32'(rf_sel), 32'd0);
        chk("reset_rf_wsel", 32'(rf_wsel), 32'd0);
        chk("reset_rf_wval", rf_wval, 32'd0);
        reset = 1'b0;
        #1;
        chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // Read register 29
        exp_q.push_back('{a: 5'd29, d: 32'h0000FFFF, e: 1'b0});
        send(1'b0, 1'b0, 5'd29, 32'd0);
        latency(lat);
        chk("read_latency", 32'(lat), 32'd3);
        wait_idle();
        chk("halt_req_after_release", 32'(halt_req), 32'd0);
        chk("rf_sel_idle", 32'(rf_sel), 32'd0);

        // Write register 8, then read it back
        we0 = we_cnt;
        exp_q.push_back('{a: 5'd8, d: 32'hDEADBEEF, e: 1'b0});
        send(1'b1, 1'b0, 5'd8, 32'hDEADBEEF);
        wait_idle();
        chk("write_we_cycles", 32'(we_cnt - we0), 32'd1);
        chk("write_wsel", 32'(last_wsel), 32'd8);
        chk("write_wval", last_wval, 32'hDEADBEEF);
        exp_q.push_back('{a: 5'd8, d: 32'hDEADBEEF, e: 1'b0});
        send(1'b0, 1'b0, 5'd8, 32'd0);
        wait_idle();

        // Write to register 0 is refused
        we0 = we_cnt;
        exp_q.push_back('{a: 5'd0, d: 32'd0, e: 1'b1});
        send(1'b1, 1'b0, 5'd0, 32'h12345678);
        wait_idle();
        chk("write0_no_we", 32'(we_cnt - we0), 32'd0);

        // Halt timeout with the CPU never acknowledging
        hold_low = 1'b1;
        we0 = we_cnt;
        exp_q.push_back('{a: 5'd5, d: 32'd0, e: 1'b1});
        send(1'b1, 1'b0, 5'd5, 32'h55555555);
        latency(lat);
        chk("timeout_latency", 32'(lat), 32'd4);
        wait_idle();
        chk("timeout_no_we", 32'(we_cnt - we0), 32'd0);
        hold_low = 1'b0;

`ifdef REG_DBG_DUMP_EN
        // Full dump under toggling backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 32; i++)
            exp_q.push_back('{a: 5'(i), d: (i == 8) ? 32'hDEADBEEF : pre(i), e: 1'b0});
        send(1'b0, 1'b1, 5'd0, 32'd0);
        wait_idle();
        bp_en = 1'b0;
        chk("dump_halt_released", 32'(halt_req), 32'd0);
`else
        // Dump flag ignored: plain read, plain write
        exp_q.push_back('{a: 5'd3, d: pre(3), e: 1'b0});
        send(1'b0, 1'b1, 5'd3, 32'd0);
        wait_idle();
        we0 = we_cnt;
        exp_q.push_back('{a: 5'd12, d: 32'hCAFEF00D, e: 1'b0});
        send(1'b1, 1'b1, 5'd12, 32'hCAFEF00D);
        wait_idle();
        chk("dump_ignored_we", 32'(we_cnt - we0), 32'd1);
        bp_en = 1'b1;
        exp_q.push_back('{a: 5'd29, d: 32'h0000FFFF, e: 1'b0});
        send(1'b0, 1'b0, 5'd29, 32'd0);
        wait_idle();
        bp_en = 1'b0;
`endif

        // Reset while a write is waiting for halt acknowledge
        hold_low = 1'b1;
        we0 = we_cnt;
        send(1'b1, 1'b0, 5'd9, 32'h11111111);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midcmd_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midcmd_halt_req", 32'(halt_req), 32'd0);
        reset = 1'b0;
        hold_low = 1'b0;
        @(negedge clk);
        chk("midcmd_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midcmd_no_we", 32'(we_cnt - we0), 32'd0);
        exp_q.push_back('{a: 5'd9, d: pre(9), e: 1'b0});
        send(1'b0, 1'b0, 5'd9, 32'd0);
        wait_idle();

`ifdef REG_DBG_DUMP_EN
        // Reset in the middle of a dump at index 10
        sb_en = 1'b0;
        send(1'b0, 1'b1, 5'd0, 32'd0);
        n = 0;
        @(negedge clk);
        while (!(rsp_valid === 1'b1 && rsp_addr == 5'd10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("dump_reached_10", 32'(n < 400), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("middump_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("middump_halt_req", 32'(halt_req), 32'd0);
        chk("middump_ready_in_reset", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("middump_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        sb_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
